// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA sequencer: on a CPU write to TRIG_ADDR it stalls the CPU, owns the bus,
// and copies one 256-byte CPU page into SPRAM through repeated writes to OAM_DATA_ADDR.
module oam_dma_ctrl #(
    parameter logic [15:0] TRIG_ADDR     = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_write_en,
    input  logic [7:0]  dma_rdata,
    output logic        cpu_stall,
    output logic        bus_grant,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_wdata,
    output logic        dma_read_en,
    output logic        dma_write_en,
    output logic        dma_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic [7:0]  data_reg;
    logic        parity;
    logic        trigger;
    logic        last_byte;

    assign trigger   = cpu_write_en && (cpu_addr == TRIG_ADDR);
    assign last_byte = (idx == 8'hFF);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers; parity runs freely so the start of each transfer can be
    // aligned to the bus's two-cycle rhythm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            page     <= 8'h00;
            idx      <= 8'h00;
            data_reg <= 8'h00;
            parity   <= 1'b0;
        end else begin
            parity <= ~parity;
            if (state == ST_IDLE && trigger) begin
                page <= cpu_data_in;
                idx  <= 8'h00;
            end
            if (state == ST_READ) begin
                data_reg <= dma_rdata;
            end
            if (state == ST_WRITE && !last_byte) begin
                idx <= idx + 8'd1;
            end
        end
    end

    // NOTE: every combinational output gets a default before the case so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (trigger) state_nxt = ST_HALT;
            ST_HALT:  state_nxt = parity ? ST_ALIGN : ST_READ;
            ST_ALIGN: state_nxt = ST_READ;
            ST_READ:  state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = last_byte ? ST_IDLE : ST_READ;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decode from state only, so an async reset releases the bus at once.
    always_comb begin
        cpu_stall    = (state != ST_IDLE);
        bus_grant    = (state != ST_IDLE);
        dma_addr     = 16'h0000;
        dma_wdata    = 8'h00;
        dma_read_en  = 1'b0;
        dma_write_en = 1'b0;
        dma_done     = 1'b0;
        unique case (state)
            ST_READ: begin
                dma_addr    = {page, idx};
                dma_read_en = 1'b1;
            end
            ST_WRITE: begin
                dma_addr     = OAM_DATA_ADDR;
                dma_wdata    = data_reg;
                dma_write_en = 1'b1;
                dma_done     = last_byte;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: models the CPU bus, a CPU page memory and the SPRAM data port
// behind 0x2003/0x2004, then checks idle vectors and full sprite-DMA transfers.
module tb_oam_dma_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_in;
    logic        cpu_write_en;
    logic [7:0]  dma_rdata;
    logic        cpu_stall;
    logic        bus_grant;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_read_en;
    logic        dma_write_en;
    logic        dma_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  mem   [0:2047];
    logic [7:0]  spram [0:255];
    logic [7:0]  spr_addr;
    logic        tb_par;

    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;

    oam_dma_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr     (cpu_addr),
        .cpu_data_in  (cpu_data_in),
        .cpu_write_en (cpu_write_en),
        .dma_rdata    (dma_rdata),
        .cpu_stall    (cpu_stall),
        .bus_grant    (bus_grant),
        .dma_addr     (dma_addr),
        .dma_wdata    (dma_wdata),
        .dma_read_en  (dma_read_en),
        .dma_write_en (dma_write_en),
        .dma_done     (dma_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Top-level mux and a small mem_decode stand-in.
    assign bus_addr  = bus_grant ? dma_addr     : cpu_addr;
    assign bus_wdata = bus_grant ? dma_wdata    : cpu_data_in;
    assign bus_we    = bus_grant ? dma_write_en : cpu_write_en;
    assign dma_rdata = mem[dma_addr[10:0]];

    always @(posedge clk) begin
        if (bus_we) begin
            if (bus_addr == 16'h2003) begin
                spr_addr <= bus_wdata;
            end else if (bus_addr == 16'h2004) begin
                spram[spr_addr] <= bus_wdata;
                spr_addr        <= spr_addr + 8'd1;
            end
        end
    end

    // Independent model of the free-running parity bit.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_par <= 1'b0;
        else     tb_par <= ~tb_par;
    end

    function automatic logic [7:0] exp_byte(input logic [7:0] pg, input int i);
        logic [7:0] b;
        b = i[7:0];
        case (pg)
            8'h02:   return b ^ 8'h5A;
            8'h03:   return b * 8'd7 + 8'd3;
            8'h04:   return ~b;
            8'h05:   return b + 8'd1;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr     = a;
        cpu_data_in  = d;
        cpu_write_en = 1'b1;
        @(negedge clk);
        cpu_write_en = 1'b0;
        cpu_addr     = 16'h0000;
        cpu_data_in  = 8'h00;
    endtask

    task automatic check_spram(input string name, input logic [7:0] pg, input logic [7:0] start,
                               input int count);
        int bad = 0;
        for (int i = 0; i < count; i++) begin
            logic [7:0] a;
            a = start + i[7:0];
            if (spram[a] !== exp_byte(pg, i)) bad++;
        end
        check(name, bad, 0);
    endtask

    // Issue a trigger at the wanted HALT parity and monitor every bus cycle until the
    // stall drops; abort_after > 0 asserts reset once that many bytes are written.
    task automatic run_dma(input string name, input logic [7:0] pg, input logic want_par,
                           input int abort_after);
        int cycles = 0, reads = 0, writes = 0, dones = 0, pre = 0, seq_err = 0, guard = 0;
        logic [15:0] first_rd = 16'hFFFF;
        logic [7:0]  exp_wd = 8'h00;
        while (tb_par == want_par && guard < 4) begin
            @(negedge clk);
            guard++;
        end
        cpu_write(16'h4014, pg);
        while (cpu_stall && cycles < 1000) begin
            cycles++;
            if (bus_grant !== cpu_stall) seq_err++;
            if (dma_read_en && dma_write_en) seq_err++;
            if (dma_read_en) begin
                if (reads == 0) first_rd = dma_addr;
                if (dma_addr !== {pg, reads[7:0]}) seq_err++;
                if (dma_done) seq_err++;
                exp_wd = exp_byte(pg, reads);
                reads++;
            end else if (dma_write_en) begin
                writes++;
                if (dma_addr !== 16'h2004 || dma_wdata !== exp_wd) seq_err++;
                if (writes != reads) seq_err++;
                if (dma_done) begin
                    dones++;
                    if (writes != 256) seq_err++;
                end else if (writes == 256) begin
                    seq_err++;
                end
            end else begin
                pre++;
                if (dma_addr !== 16'h0000 || dma_wdata !== 8'h00 || dma_done) seq_err++;
            end
            if (abort_after > 0 && writes == abort_after) begin
                @(negedge clk);
                rst = 1'b1;
                #1;
                check({name, "_rst_stall"}, {cpu_stall, bus_grant}, 2'b00);
                check({name, "_rst_bus"}, {dma_addr, dma_read_en, dma_write_en, dma_done}, 19'h0);
                repeat (3) @(negedge clk);
                check({name, "_rst_hold"}, {cpu_stall, bus_grant, dma_done}, 3'b000);
                check({name, "_seq"}, seq_err, 0);
                rst = 1'b0;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        check({name, "_stall_cycles"}, cycles, 513 + int'(want_par));
        check({name, "_pre_cycles"}, pre, 1 + int'(want_par));
        check({name, "_first_read"}, first_rd, {pg, 8'h00});
        check({name, "_writes"}, writes, 256);
        check({name, "_done_pulses"}, dones, 1);
        check({name, "_seq"}, seq_err, 0);
        check({name, "_released"}, {cpu_stall, bus_grant, dma_read_en, dma_write_en}, 4'b0000);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        we;
        logic        exp_stall;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{16'h4013, 8'h02, 1'b1, 1'b0};
        vecs[1] = '{16'h4015, 8'h02, 1'b1, 1'b0};
        vecs[2] = '{16'h2004, 8'hAA, 1'b1, 1'b0};
        vecs[3] = '{16'h4014, 8'h02, 1'b0, 1'b0};
        vecs[4] = '{16'h0014, 8'h02, 1'b1, 1'b0};
        vecs[5] = '{16'hC014, 8'h03, 1'b1, 1'b0};

        for (int i = 0; i < 2048; i++) begin
            logic [7:0] pg;
            pg = i[15:8];
            mem[i] = exp_byte(pg, i & 255);
        end

        rst          = 1'b1;
        cpu_addr     = 16'h0000;
        cpu_data_in  = 8'h00;
        cpu_write_en = 1'b0;
        #1;
        check("reset_outputs",
              {cpu_stall, bus_grant, dma_addr, dma_wdata, dma_read_en, dma_write_en, dma_done},
              31'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cpu_write(16'h2003, 8'h00);

        for (int i = 0; i < 6; i++) begin
            cpu_addr     = vecs[i].addr;
            cpu_data_in  = vecs[i].data;
            cpu_write_en = vecs[i].we;
            @(negedge clk);
            cpu_write_en = 1'b0;
            check($sformatf("vec%0d_stall", i), {cpu_stall, bus_grant},
                  {vecs[i].exp_stall, vecs[i].exp_stall});
            check($sformatf("vec%0d_bus", i), {dma_read_en, dma_write_en, dma_addr}, 18'h0);
            @(negedge clk);
            check($sformatf("vec%0d_stall_later", i), cpu_stall, vecs[i].exp_stall);
        end

        cpu_write(16'h2003, 8'h00);
        run_dma("even", 8'h02, 1'b0, 0);
        check_spram("even_spram", 8'h02, 8'h00, 256);

        cpu_write(16'h2003, 8'h00);
        run_dma("odd", 8'h02, 1'b1, 0);
        check_spram("odd_spram", 8'h02, 8'h00, 256);

        cpu_write(16'h2003, 8'h00);
        run_dma("page3", 8'h03, 1'b0, 0);
        check_spram("page3_spram", 8'h03, 8'h00, 256);
        run_dma("b2b", 8'h05, ~tb_par, 0);
        check_spram("b2b_spram", 8'h05, 8'h00, 256);

        cpu_write(16'h2003, 8'hF0);
        run_dma("wrap", 8'h04, 1'b0, 0);
        check_spram("wrap_spram", 8'h04, 8'hF0, 256);

        cpu_write(16'h2003, 8'h00);
        for (int i = 0; i < 256; i++) cpu_write(16'h2004, 8'hEE);
        cpu_write(16'h2003, 8'h00);
        run_dma("abort", 8'h02, 1'b0, 100);
        check_spram("abort_partial", 8'h02, 8'h00, 100);
        check("abort_byte100_untouched", spram[100], 8'hEE);

        cpu_write(16'h2003, 8'h00);
        run_dma("after_rst", 8'h02, 1'b1, 0);
        check_spram("after_rst_spram", 8'h02, 8'h00, 256);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

Sprite-DMA sequencer that implements the CPU-side write to 0x4014. On that write it halts the CPU, takes over the system bus in front of `mem_decode`, and copies the 256-byte CPU page `{page, 8'h00}`..`{page, 8'hFF}` into SPRAM through repeated writes to 0x2004, then hands the bus back. It sits between the CPU core and `mem_decode`; the top level muxes `dma_addr`/`dma_wdata`/`dma_write_en`/`dma_read_en` onto `mem_decode`'s CPU port while `bus_grant` is high.

## Interface
- `TRIG_ADDR`, 16'h4014, CPU address whose write starts a transfer
- `OAM_DATA_ADDR`, 16'h2004, SPRAM data-port address used as write target
- `clk` input 1: system clock; all state on rising edge
- `rst` input 1: asynchronous, active-high reset
- `cpu_addr` input 16: CPU bus address, sampled for trigger detection
- `cpu_data_in` input 8: CPU write data; holds the page number on trigger
- `cpu_write_en` input 1: CPU write strobe
- `dma_rdata` input 8: read data returned by `mem_decode` for `dma_addr`
- `cpu_stall` output 1: halts the CPU core while high
- `bus_grant` output 1: selects DMA as bus master at the top-level mux
- `dma_addr` output 16: bus address during DMA
- `dma_wdata` output 8: bus write data during DMA
- `dma_read_en` output 1: read strobe (READ cycles)
- `dma_write_en` output 1: write strobe (WRITE cycles)
- `dma_done` output 1: one-cycle pulse on the final WRITE cycle

## Operation
- Registers: `state`, `page[7:0]`, `idx[7:0]`, `data_reg[7:0]`, `parity` (free-running toggle, flips every clock).
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE: trigger = `cpu_write_en && cpu_addr == TRIG_ADDR`. On trigger: `page <= cpu_data_in`, `idx <= 0`, go to HALT.
- HALT (1 cycle): go to ALIGN if `parity == 1`, else go to READ.
- ALIGN (1 cycle): go to READ.
- READ: `dma_addr = {page, idx}`, `dma_read_en = 1`. `dma_rdata` must be valid within this cycle; it is latched into `data_reg` at the closing edge. Go to WRITE.
- WRITE: `dma_addr = OAM_DATA_ADDR`, `dma_wdata = data_reg`, `dma_write_en = 1`. If `idx == 8'hFF`, pulse `dma_done` and go to IDLE. Otherwise `idx <= idx + 1` (8-bit) and go to READ.
- `cpu_stall = bus_grant = (state != IDLE)`.
- SPRAM destination addressing relies on `mem_decode` auto-incrementing its SPRAM address on each 0x2004 write. The DMA does not touch 0x2003, so the copy starts at the current SPRAM address and wraps mod 256.
- In IDLE, and in HALT/ALIGN: `dma_addr = 0`, `dma_wdata = 0`, both strobes 0.
- Triggers outside IDLE are ignored (the CPU is stalled, so none are expected).
- A page value of 0x20–0x3F is not special-cased: reads go to the register space exactly as `mem_decode` decodes them.

## Timing
- Reset (async, immediate): `state = IDLE`, `page = 0`, `idx = 0`, `data_reg = 0`, `parity = 0`. All outputs are 0.
- Reset mid-transfer: the bus is released and `cpu_stall` drops immediately. The partial SPRAM contents remain. No `dma_done` is generated.
- Let the trigger be sampled at edge E0. `cpu_stall`/`bus_grant` are high from E0 through the edge ending the last WRITE cycle.
  - Stall length is 513 cycles (even parity) or 514 cycles (odd parity): 1 HALT + optional ALIGN + 256 × (READ, WRITE).
- Read-to-write latency: 1 cycle. Byte k is read in cycle 2k and written in cycle 2k+1, counted from the first READ.
- `dma_done` is high during the 256th WRITE cycle only. In the following cycle, `state = IDLE` and the CPU resumes.
- A trigger in the first IDLE cycle after completion is accepted (back-to-back DMA is allowed).

## Test plan
- Even-parity trigger: preload CPU page 0x02 with `mem[0x0200+i] = i ^ 8'h5A`, write 0x02 to 0x4014 with `parity = 0` → `cpu_stall` high for exactly 513 cycles, 256 writes to 0x2004, and SPRAM[i] = i ^ 0x5A.
- Odd-parity trigger: same stimulus with `parity = 1` at HALT → exactly one ALIGN cycle and 514 stall cycles. First READ has `dma_addr = 0x0200`.
- Address sequence check: `dma_addr` alternates 0x0300, 0x2004, 0x0301, 0x2004, …, 0x03FF, 0x2004. `dma_done` is a single pulse coincident with the last 0x2004 write.
- SPRAM wrap: set SPRAM address to 0xF0 via 0x2003, then DMA page 0x04 → SPRAM[(0xF0+i) & 0xFF] = `mem[0x0400+i]` for all i.
- Reset mid-transfer: assert `rst` after byte 100 is written → `cpu_stall` and `bus_grant` go low immediately and stay low. Bytes 0–99 are present. A new 0x4014 write after reset runs a full 513/514-cycle transfer.
- Non-trigger writes: writes to 0x4013, 0x4015 and 0x2004 while IDLE → no stall and no DMA bus activity.
